// File: rtl/if_id_stage_if.sv
// IF/ID stage bundle: the fetch-side inputs (PC+4, instruction, redirect
// requests), the ID/EX load information used for hazard detection, and the
// latched outputs / stall controls produced by the IF/ID stage.
//   master : fetch/decode environment driving the stage
//   slave  : the if_id_stage itself
interface if_id_stage_if;
    logic [31:0] pc_add_in;
    logic [31:0] inst_in;
    logic        PCSrc;
    logic        Jump;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_rt;
    logic        PCWrite;
    logic [31:0] pc_add_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic        bubble;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;

    modport master (
        output pc_add_in, inst_in, PCSrc, Jump, id_ex_MemRead, id_ex_rt,
        input  PCWrite, pc_add_out, inst_out, valid_out, bubble, rs_out, rt_out
    );

    modport slave (
        input  pc_add_in, inst_in, PCSrc, Jump, id_ex_MemRead, id_ex_rt,
        output PCWrite, pc_add_out, inst_out, valid_out, bubble, rs_out, rt_out
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline latch with load-use hazard stall and branch/jump flush.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - if_id_stage_if.slave: pc_add_in/inst_in from fetch, PCSrc/Jump
//          redirect requests, id_ex_MemRead/id_ex_rt from ID/EX; drives
//          PCWrite back to fetch plus the latched pc_add_out/inst_out,
//          valid_out, bubble and the rs_out/rt_out register fields.
module if_id_stage #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        valid_r;
    logic        flush_s;
    logic        hazard_s;
    logic        hold_s;

    // Opcodes whose rt field is a source operand (R-type, beq, bne, sw).
    function automatic logic uses_rt(input logic [5:0] opcode);
        case (opcode)
            6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
            default:                    uses_rt = 1'b0;
        endcase
    endfunction

    assign flush_s = bus.PCSrc | bus.Jump;

    // Load-use hazard detection, only evaluated while not already stalling.
    always_comb begin
        hazard_s = 1'b0;
        if (state_r == RUN && valid_r && bus.id_ex_MemRead && bus.id_ex_rt != 5'd0) begin
            if (bus.id_ex_rt == inst_r[25:21]) begin
                hazard_s = 1'b1;
            end else if (bus.id_ex_rt == inst_r[20:16] && uses_rt(inst_r[31:26])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign hold_s = hazard_s | (state_r == STALL);

    // Fetch control: a flush always lets the PC redirect; reset forces run.
    always_comb begin
        bus.PCWrite = 1'b1;
        bus.bubble  = 1'b0;
        if (rst) begin
            bus.PCWrite = 1'b1;
            bus.bubble  = 1'b0;
        end else begin
            bus.PCWrite = ~hold_s | flush_s;
            bus.bubble  = hold_s & ~flush_s;
        end
    end

    // Stall sequencer next state; counter holds the remaining stall cycles.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush_s) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s && STALL_CYCLES > 32'd1) begin
                        state_nxt_s = STALL;
                        cnt_nxt_s   = 3'(STALL_CYCLES - 32'd1);
                    end else begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = 3'd0;
                    end
                end
                STALL: begin
                    if (cnt_r <= 3'd1) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = STALL;
                        cnt_nxt_s   = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // Stall sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // IF/ID latch: reset > flush > hold > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= 32'h0000_0000;
            inst_r  <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (flush_s) begin
            pc_r    <= bus.pc_add_in;
            inst_r  <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (hold_s) begin
            pc_r    <= pc_r;
            inst_r  <= inst_r;
            valid_r <= valid_r;
        end else begin
            pc_r    <= bus.pc_add_in;
            inst_r  <= bus.inst_in;
            valid_r <= 1'b1;
        end
    end

    assign bus.pc_add_out = pc_r;
    assign bus.inst_out   = inst_r;
    assign bus.valid_out  = valid_r;
    assign bus.rs_out     = inst_r[25:21];
    assign bus.rt_out     = inst_r[20:16];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: two instances (STALL_CYCLES 1 and 3)
// share the same stimulus; a reference model pushes the expected per-cycle
// view into one queue per instance and a negedge monitor compares.
module tb_if_id_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        pcw;
        logic        bub;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        ps_in;
    logic        j_in;
    logic        mr_in;
    logic [4:0]  rt_in;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q3[$];

    logic [31:0] m_pc[2];
    logic [31:0] m_inst[2];
    logic        m_valid[2];
    int          m_left[2];
    int          stall_of[2];

    always #5 clk = ~clk;

    if_id_stage_if bus1();
    if_id_stage_if bus3();

    assign bus1.pc_add_in     = pc_in;
    assign bus1.inst_in       = inst_in;
    assign bus1.PCSrc         = ps_in;
    assign bus1.Jump          = j_in;
    assign bus1.id_ex_MemRead = mr_in;
    assign bus1.id_ex_rt      = rt_in;
    assign bus3.pc_add_in     = pc_in;
    assign bus3.inst_in       = inst_in;
    assign bus3.PCSrc         = ps_in;
    assign bus3.Jump          = j_in;
    assign bus3.id_ex_MemRead = mr_in;
    assign bus3.id_ex_rt      = rt_in;

    if_id_stage #(.STALL_CYCLES(1), .NOP_WORD(32'h0000_0000)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );
    if_id_stage #(.STALL_CYCLES(3), .NOP_WORD(32'h0000_0000)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    endfunction

    // Monitor: compare what each instance presents against the model.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("s1 pc_add_out", bus1.pc_add_out, e.pc);
            chk("s1 inst_out",   bus1.inst_out,   e.inst);
            chk("s1 valid_out",  32'(bus1.valid_out), 32'(e.valid));
            chk("s1 PCWrite",    32'(bus1.PCWrite),   32'(e.pcw));
            chk("s1 bubble",     32'(bus1.bubble),    32'(e.bub));
            chk("s1 rs_out",     32'(bus1.rs_out),    32'(e.inst[25:21]));
            chk("s1 rt_out",     32'(bus1.rt_out),    32'(e.inst[20:16]));
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("s3 pc_add_out", bus3.pc_add_out, e.pc);
            chk("s3 inst_out",   bus3.inst_out,   e.inst);
            chk("s3 valid_out",  32'(bus3.valid_out), 32'(e.valid));
            chk("s3 PCWrite",    32'(bus3.PCWrite),   32'(e.pcw));
            chk("s3 bubble",     32'(bus3.bubble),    32'(e.bub));
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = 32'h0;
            m_inst[k]  = 32'h0;
            m_valid[k] = 1'b0;
            m_left[k]  = 0;
        end
    endtask

    // One cycle: drive inputs, record expected view, advance the model.
    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ps, input logic j, input logic mr, input logic [4:0] rt);
        exp_t e;
        logic fl;
        logic hz;
        logic hd;
        rst = r; pc_in = pc; inst_in = inst; ps_in = ps; j_in = j; mr_in = mr; rt_in = rt;
        fl = ps | j;
        for (int k = 0; k < 2; k++) begin
            hz = (m_left[k] == 0) && m_valid[k] && mr && (rt != 5'd0) &&
                 ((rt == m_inst[k][25:21]) ||
                  ((rt == m_inst[k][20:16]) && reads_rt(m_inst[k][31:26])));
            hd = (m_left[k] > 0) || hz;
            e.pc    = m_pc[k];
            e.inst  = m_inst[k];
            e.valid = m_valid[k];
            e.pcw   = r ? 1'b1 : (!hd || fl);
            e.bub   = r ? 1'b0 : (hd && !fl);
            if (k == 0) q1.push_back(e);
            else        q3.push_back(e);
            if (r) begin
                m_pc[k] = 32'h0; m_inst[k] = 32'h0; m_valid[k] = 1'b0; m_left[k] = 0;
            end else if (fl) begin
                m_pc[k] = pc; m_inst[k] = 32'h0; m_valid[k] = 1'b0; m_left[k] = 0;
            end else if (hd) begin
                if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                else               m_left[k] = stall_of[k] - 1;
            end else begin
                m_pc[k] = pc; m_inst[k] = inst; m_valid[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            step(1'b0, base + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 5'd0);
        end
    endtask

    initial begin
        logic [31:0] ri;
        logic [4:0]  rr;
        logic [5:0]  ops[6];
        int          sel;
        stall_of[0] = 1;
        stall_of[1] = 3;
        ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
        ops[3] = 6'h2B; ops[4] = 6'h23; ops[5] = 6'h08;
        rst = 1'b1; pc_in = 32'h40; inst_in = 32'h8C08_0004;
        ps_in = 1'b0; j_in = 1'b0; mr_in = 1'b0; rt_in = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        // Reset held with live fetch data
        step(1'b1, 32'h40, 32'h8C08_0004, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 32'h40, 32'h8C08_0004, 1'b0, 1'b0, 1'b0, 5'd0);
        // Pipelined loads
        step(1'b0, 32'd4,  32'h1111_0001, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd8,  32'h2222_0002, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd12, 32'h3333_0003, 1'b0, 1'b0, 1'b0, 5'd0);
        // Load-use on rs: add $10,$8,$9 against lw $8
        step(1'b0, 32'd16, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd20, 32'h4444_0004, 1'b0, 1'b0, 1'b1, 5'd8);
        idle(5, 32'd24);
        // rt-only dependence: sw stalls, lw does not, rt=0 never
        step(1'b0, 32'd60, 32'hAD09_0000, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd64, 32'h5555_0005, 1'b0, 1'b0, 1'b1, 5'd9);
        idle(5, 32'd68);
        step(1'b0, 32'd100, 32'h8D09_0000, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd104, 32'h6666_0006, 1'b0, 1'b0, 1'b1, 5'd9);
        step(1'b0, 32'd108, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd112, 32'h7777_0007, 1'b0, 1'b0, 1'b1, 5'd0);
        // Flush together with a hazard (PCSrc, then Jump)
        step(1'b0, 32'd116, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd200, 32'h8888_0008, 1'b1, 1'b0, 1'b1, 5'd8);
        step(1'b0, 32'd204, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd300, 32'h9999_0009, 1'b0, 1'b1, 1'b1, 5'd9);
        idle(2, 32'd304);
        // Flush in the second stall cycle
        step(1'b0, 32'd320, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd324, 32'hAAAA_000A, 1'b0, 1'b0, 1'b1, 5'd8);
        step(1'b0, 32'd400, 32'hBBBB_000B, 1'b1, 1'b0, 1'b0, 5'd0);
        idle(3, 32'd404);
        // Reset during a stall
        step(1'b0, 32'd420, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'd424, 32'hCCCC_000C, 1'b0, 1'b0, 1'b1, 5'd9);
        step(1'b1, 32'd428, 32'hDDDD_000D, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(3, 32'd432);

        // Randomized traffic biased toward real dependences
        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            ri[31:26] = ops[$urandom_range(0, 5)];
            sel = $urandom_range(0, 3);
            if (sel == 0)      rr = m_inst[1][25:21];
            else if (sel == 1) rr = m_inst[1][20:16];
            else if (sel == 2) rr = m_inst[0][20:16];
            else               rr = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 49) == 0), $urandom, ri,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 1) == 1), rr);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(q1.size() + q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
